// File: rtl/snoop_sequencer.sv
// snoop_sequencer: fetches CPU-tagged instructions, arbitrates for the shared
// bus, runs a snoop window on the listening CPUs and hands execution to the
// issuing CPU.
// Ports: clock/clear (sync active-low), start, imem_we/imem_addr/imem_wdata
// (instruction load), bus_req/bus_msg/bus_gnt (arbiter), cpu_en/cpu_issuer/inst/
// snoop_shared/shared/cpu_done (CPU side), pc/busy/halted/err (status).
// Optional feature: define SNOOP_TIMEOUT_EN to bound the ARB and EXEC waits.
module snoop_sequencer #(
   parameter int NUM_CPU    = 3,
   parameter int TAG_W      = 3,
   parameter int IMEM_DEPTH = 32,
   parameter int BUS_W      = 10,
   parameter int SNOOP_CYC  = 2,
   parameter int TIMEOUT    = 15,
   localparam int ID_W      = $clog2(NUM_CPU),
   localparam int PC_W      = $clog2(IMEM_DEPTH),
   localparam int INST_W    = 2 + ID_W + TAG_W
) (
   input  logic               clock,
   input  logic               clear,
   input  logic               start,
   input  logic               imem_we,
   input  logic [PC_W-1:0]    imem_addr,
   input  logic [INST_W-1:0]  imem_wdata,
   output logic               bus_req,
   output logic [BUS_W-1:0]   bus_msg,
   input  logic               bus_gnt,
   output logic [NUM_CPU-1:0] cpu_en,
   output logic [NUM_CPU-1:0] cpu_issuer,
   output logic [INST_W-1:0]  inst,
   input  logic [NUM_CPU-1:0] snoop_shared,
   output logic               shared,
   input  logic [NUM_CPU-1:0] cpu_done,
   output logic [PC_W-1:0]    pc,
   output logic               busy,
   output logic               halted,
   output logic               err
);

   if (NUM_CPU < 2 || BUS_W < 4 + TAG_W || SNOOP_CYC < 1 || TIMEOUT < 1)
   begin : g_bad_cfg
      $error("snoop_sequencer: illegal parameter set");
   end

   typedef enum logic [2:0] {
      IDLE, FETCH, DECODE, ARB, SNOOP, EXEC
   } state_t;

   localparam int SC_W = $clog2(SNOOP_CYC + 1);

   state_t            state;
   logic [INST_W-1:0] imem [IMEM_DEPTH];
   logic [SC_W-1:0]   scnt;

   logic               cur_halt;
   logic [ID_W-1:0]    cur_id;
   logic               cur_op;
   logic [TAG_W-1:0]   cur_tag;
   logic               bad_id;
   logic [BUS_W-1:0]   next_msg;
   logic               snoop_last;
   logic               done_hit;

   // Memory is not reset; the write lands at the edge, so a same-cycle
   // fetch of that address still sees the old word.
   always_ff @(posedge clock) begin
      if (imem_we) imem[imem_addr] <= imem_wdata;
   end

   assign cur_halt   = inst[INST_W-1];
   assign cur_id     = inst[INST_W-2 -: ID_W];
   assign cur_op     = inst[TAG_W];
   assign cur_tag    = inst[TAG_W-1:0];
   assign bad_id     = 32'(cur_id) >= 32'(NUM_CPU);
   assign snoop_last = scnt == SC_W'(SNOOP_CYC - 1);
   assign done_hit   = |(cpu_done & cpu_issuer);
   assign busy       = state != IDLE;

   always_comb begin
      next_msg = '0;
      next_msg[BUS_W-1 -: 4] = cur_op ? 4'b0100 : 4'b0011;
      next_msg[BUS_W-5 -: TAG_W] = cur_tag;
   end

`ifdef SNOOP_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] wcnt;
   logic            wait_exp;
   assign wait_exp = wcnt == TO_W'(TIMEOUT - 1);
`endif

   always_ff @(posedge clock) begin
      if (!clear) begin
         state      <= IDLE;
         pc         <= '0;
         inst       <= '0;
         bus_req    <= 1'b0;
         bus_msg    <= '0;
         cpu_en     <= '0;
         cpu_issuer <= '0;
         shared     <= 1'b0;
         halted     <= 1'b0;
         err        <= 1'b0;
         scnt       <= '0;
`ifdef SNOOP_TIMEOUT_EN
         wcnt       <= '0;
`endif
      end else begin
         halted <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  err   <= 1'b0;
                  state <= FETCH;
               end
            end
            FETCH: begin
               inst  <= imem[pc];
               pc    <= pc + 1'b1;
               state <= DECODE;
            end
            DECODE: begin
               if (cur_halt) begin
                  halted <= 1'b1;
                  state  <= IDLE;
               end else if (bad_id) begin
                  err   <= 1'b1;
                  state <= FETCH;
               end else begin
                  cpu_issuer <= NUM_CPU'(1) << cur_id;
                  bus_req    <= 1'b1;
                  bus_msg    <= next_msg;
                  state      <= ARB;
`ifdef SNOOP_TIMEOUT_EN
                  wcnt       <= '0;
`endif
               end
            end
            ARB: begin
               if (bus_gnt) begin
                  bus_req <= 1'b0;
                  cpu_en  <= ~cpu_issuer;
                  scnt    <= '0;
                  state   <= SNOOP;
               end
`ifdef SNOOP_TIMEOUT_EN
               else if (wait_exp) begin
                  err        <= 1'b1;
                  bus_req    <= 1'b0;
                  cpu_en     <= '0;
                  cpu_issuer <= '0;
                  state      <= FETCH;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
`endif
            end
            SNOOP: begin
               if (snoop_last) begin
                  // Only the listeners count; the issuer's own line is masked.
                  shared <= |(snoop_shared & ~cpu_issuer);
                  cpu_en <= cpu_issuer;
                  state  <= EXEC;
`ifdef SNOOP_TIMEOUT_EN
                  wcnt   <= '0;
`endif
               end else begin
                  scnt <= scnt + 1'b1;
               end
            end
            EXEC: begin
               if (done_hit) begin
                  cpu_en     <= '0;
                  cpu_issuer <= '0;
                  state      <= FETCH;
               end
`ifdef SNOOP_TIMEOUT_EN
               else if (wait_exp) begin
                  err        <= 1'b1;
                  cpu_en     <= '0;
                  cpu_issuer <= '0;
                  state      <= FETCH;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_snoop_sequencer.sv
// tb_snoop_sequencer: directed table, hand sequences and a randomized
// program run checked against a program-walking reference model.
module tb_snoop_sequencer;

   localparam int NUM_CPU    = 3;
   localparam int TAG_W      = 3;
   localparam int IMEM_DEPTH = 32;
   localparam int BUS_W      = 10;
   localparam int SNOOP_CYC  = 2;
   localparam int TIMEOUT    = 15;
   localparam logic [6:0] HALT = 7'b1000000;

   logic       clock = 1'b0;
   logic       clear, start, imem_we;
   logic [4:0] imem_addr;
   logic [6:0] imem_wdata;
   logic       bus_req;
   logic [9:0] bus_msg;
   logic       bus_gnt;
   logic [2:0] cpu_en, cpu_issuer;
   logic [6:0] inst;
   logic [2:0] snoop_shared;
   logic       shared;
   logic [2:0] cpu_done;
   logic [4:0] pc;
   logic       busy, halted, err;

   int errors = 0;
   int checks = 0;

   logic [6:0] ref_mem [IMEM_DEPTH];
   int         ref_pc;
   logic       ref_err;

   always #5 clock = ~clock;

   snoop_sequencer #(
      .NUM_CPU(NUM_CPU), .TAG_W(TAG_W), .IMEM_DEPTH(IMEM_DEPTH),
      .BUS_W(BUS_W), .SNOOP_CYC(SNOOP_CYC), .TIMEOUT(TIMEOUT)
   ) dut (
      .clock(clock), .clear(clear), .start(start),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .bus_req(bus_req), .bus_msg(bus_msg), .bus_gnt(bus_gnt),
      .cpu_en(cpu_en), .cpu_issuer(cpu_issuer), .inst(inst),
      .snoop_shared(snoop_shared), .shared(shared), .cpu_done(cpu_done),
      .pc(pc), .busy(busy), .halted(halted), .err(err)
   );

   typedef struct {
      logic [6:0] word;
      int         gd;
      int         dd;
      logic [2:0] ss;
      logic [9:0] msg;
      logic [2:0] iss;
      logic [2:0] en;
      logic       sh;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic wr(input int a, input logic [6:0] w);
      imem_we    = 1'b1;
      imem_addr  = 5'(a);
      imem_wdata = w;
      ref_mem[a] = w;
      @(negedge clock);
      imem_we = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic xact(input string nm, input logic [9:0] emsg,
                       input logic [2:0] eiss, input logic [2:0] een,
                       input int gd, input int dd, input logic [2:0] ss,
                       input logic esh, input int epc);
      int n;
      n = 0;
      while (!bus_req && !halted && n < 200) begin
         n++;
         @(negedge clock);
      end
      chk({nm, " req"}, 32'(bus_req), 1);
      if (!bus_req) return;
      chk({nm, " msg"}, 32'(bus_msg), 32'(emsg));
      chk({nm, " iss"}, 32'(cpu_issuer), 32'(eiss));
      chk({nm, " pc"}, 32'(pc), 32'(epc));
      snoop_shared = ss;
      for (int i = 0; i < gd; i++) @(negedge clock);
      chk({nm, " hold"}, 32'({bus_req, bus_msg}), 32'({1'b1, emsg}));
      bus_gnt = 1'b1;
      @(negedge clock);
      bus_gnt = 1'b0;
      chk({nm, " drop"}, 32'(bus_req), 0);
      n = 0;
      while (cpu_en == een && n < 20) begin
         n++;
         @(negedge clock);
      end
      chk({nm, " snooplen"}, 32'(n), 32'(SNOOP_CYC));
      chk({nm, " exec_en"}, 32'(cpu_en), 32'(eiss));
      chk({nm, " shared"}, 32'(shared), 32'(esh));
      for (int i = 0; i < dd; i++) begin
         cpu_done = 3'($urandom) & ~eiss;
         @(negedge clock);
      end
      chk({nm, " wait"}, 32'(cpu_en), 32'(eiss));
      cpu_done = eiss | 3'($urandom);
      @(negedge clock);
      cpu_done = 3'b000;
      chk({nm, " done"}, 32'({cpu_en, cpu_issuer}), 0);
   endtask

   task automatic wait_halt(input string nm, input int epc,
                            input logic eerr);
      int n;
      n = 0;
      while (!halted && n < 200) begin
         n++;
         @(negedge clock);
      end
      chk({nm, " halted"}, 32'(halted), 1);
      chk({nm, " idle"}, 32'({busy, bus_req}), 0);
      chk({nm, " hpc"}, 32'(pc), 32'(epc));
      chk({nm, " herr"}, 32'(err), 32'(eerr));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int         n;
      int         len;
      int         id;
      logic [6:0] w;
      logic [2:0] ss;
      logic [2:0] iss;

      tbl[0] = '{7'b0011101, 3, 2, 3'b000, 10'b0100101000, 3'b010, 3'b101, 1'b0};
      tbl[1] = '{7'b0000010, 1, 0, 3'b010, 10'b0011010000, 3'b001, 3'b110, 1'b1};
      tbl[2] = '{7'b0001111, 2, 3, 3'b001, 10'b0100111000, 3'b001, 3'b110, 1'b0};
      tbl[3] = '{7'b0100000, 0, 0, 3'b100, 10'b0011000000, 3'b100, 3'b011, 1'b0};
      tbl[4] = '{7'b0101011, 4, 1, 3'b011, 10'b0100011000, 3'b100, 3'b011, 1'b1};
      tbl[5] = '{7'b0010110, 0, 4, 3'b111, 10'b0011110000, 3'b010, 3'b101, 1'b1};

      clear        = 1'b0;
      start        = 1'b0;
      imem_we      = 1'b0;
      imem_addr    = '0;
      imem_wdata   = '0;
      bus_gnt      = 1'b0;
      snoop_shared = 3'b000;
      cpu_done     = 3'b000;
      repeat (2) @(negedge clock);
      chk("reset a", 32'({pc, inst, bus_req, bus_msg}), 0);
      chk("reset b", 32'({cpu_en, cpu_issuer, shared, busy, halted, err}), 0);
      clear = 1'b1;

      // single write instruction then halt
      wr(0, 7'b0011101);
      wr(1, HALT);
      go();
      xact("t2", 10'b0100101000, 3'b010, 3'b101, 3, 2, 3'b000, 1'b0, 1);
      wait_halt("t2", 2, 1'b0);

      // directed table run as one program
      for (int i = 0; i < 6; i++) wr(2 + i, tbl[i].word);
      wr(8, HALT);
      go();
      for (int i = 0; i < 6; i++)
         xact($sformatf("tbl%0d", i), tbl[i].msg, tbl[i].iss, tbl[i].en,
              tbl[i].gd, tbl[i].dd, tbl[i].ss, tbl[i].sh, 3 + i);
      wait_halt("tbl", 9, 1'b0);
      chk("shared held", 32'(shared), 1);

      // bad cpu id skipped, err sticky until next start
      wr(9, 7'b0111001);
      wr(10, 7'b0000001);
      wr(11, HALT);
      go();
      xact("t4", 10'b0011001000, 3'b001, 3'b110, 1, 1, 3'b110, 1'b1, 11);
      chk("t4 err", 32'(err), 1);
      wait_halt("t4", 12, 1'b1);
      wr(12, HALT);
      go();
      chk("t4 errclr", 32'({busy, err}), 32'(2'b10));
      wait_halt("t4b", 13, 1'b0);

      // reset in the middle of EXEC
      wr(13, 7'b0101100);
      go();
      n = 0;
      while (!bus_req && n < 50) begin
         n++;
         @(negedge clock);
      end
      chk("t1 msg", 32'(bus_msg), 32'(10'b0100100000));
      bus_gnt = 1'b1;
      @(negedge clock);
      bus_gnt = 1'b0;
      repeat (SNOOP_CYC) @(negedge clock);
      chk("t1 exec", 32'(cpu_en), 32'(3'b100));
      clear = 1'b0;
      @(negedge clock);
      chk("t1 rst a", 32'({pc, inst, bus_req, bus_msg}), 0);
      chk("t1 rst b", 32'({cpu_en, cpu_issuer, shared, busy, halted, err}), 0);
      clear = 1'b1;
      go();
      xact("t1 mem", 10'b0100101000, 3'b010, 3'b101, 0, 0, 3'b000, 1'b0, 1);
      wait_halt("t1 mem", 2, 1'b0);

      // pc wrap: skip through bad ids to 31, then 0
      for (int a = 2; a < 31; a++) wr(a, 7'b0110000);
      wr(31, 7'b0001010);
      wr(0, 7'b0100111);
      go();
      xact("t5 a31", 10'b0100010000, 3'b001, 3'b110, 1, 1, 3'b010, 1'b1, 0);
      xact("t5 a0", 10'b0011111000, 3'b100, 3'b011, 0, 2, 3'b100, 1'b0, 1);
      wait_halt("t5", 2, 1'b1);

      // long grant wait
      wr(2, 7'b0010001);
      wr(3, HALT);
      go();
`ifdef SNOOP_TIMEOUT_EN
      n = 0;
      while (!bus_req && n < 50) begin
         n++;
         @(negedge clock);
      end
      chk("t6 req", 32'(bus_req), 1);
      n = 0;
      while (bus_req && n < 50) begin
         n++;
         @(negedge clock);
      end
      chk("t6 timeout", 32'(n), 32'(TIMEOUT));
      chk("t6 err", 32'(err), 1);
      chk("t6 iss", 32'({cpu_issuer, cpu_en}), 0);
      wait_halt("t6", 4, 1'b1);
`else
      xact("t6", 10'b0011001000, 3'b010, 3'b101, 25, 3, 3'b101, 1'b1, 3);
      wait_halt("t6", 4, 1'b0);
`endif

      // random programs against the program-walking model
      ref_pc = 4;
      for (int r = 0; r < 10; r++) begin
         len = $urandom_range(1, 6);
         for (int k = 0; k < len; k++)
            wr((ref_pc + k) % IMEM_DEPTH, 7'($urandom) & 7'h3f);
         wr((ref_pc + len) % IMEM_DEPTH, HALT);
         ref_err = 1'b0;
         go();
         for (int k = 0; k <= len; k++) begin
            w = ref_mem[ref_pc];
            ref_pc = (ref_pc + 1) % IMEM_DEPTH;
            id = int'(w[5:4]);
            if (w[6]) begin
               wait_halt($sformatf("rnd%0d", r), ref_pc, ref_err);
               break;
            end else if (id >= NUM_CPU) begin
               ref_err = 1'b1;
            end else begin
               iss = 3'b001 << id;
               ss  = 3'($urandom);
               xact($sformatf("rnd%0d.%0d", r, k),
                    {(w[3] ? 4'b0100 : 4'b0011), w[2:0], 3'b000},
                    iss, ~iss, $urandom_range(0, 4), $urandom_range(0, 4),
                    ss, |(ss & ~iss), ref_pc);
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
